// File: rtl/prog_sequencer_if.sv
// Handshake bundle between prog_sequencer and its host: the program-load port and the output-value FIFO port.
interface prog_sequencer_if;
    logic       load_valid;
    logic [2:0] load_data;
    logic       load_ready;
    logic [2:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output load_valid, load_data, out_ready,
        input  load_ready, out_data, out_valid
    );

    modport slave (
        input  load_valid, load_data, out_ready,
        output load_ready, out_data, out_valid
    );
endinterface

// File: rtl/prog_sequencer.sv
// Program store, opcode decode and IDLE/LOAD/START_RST/RUN/DONE run control for the 3-bit-opcode execute stage,
// with a valid/ready FIFO buffering the values the program outputs.
module prog_sequencer #(
    parameter int OUT_DEPTH = 8,
    parameter int CYC_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    prog_sequencer_if.slave  bus,
    input  logic             load_start,
    input  logic             start,
    output logic             prog_loaded,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic             exec_rst_n,
    input  logic [3:0]       exec_instr_ptr,
    input  logic             exec_halt,
    input  logic [2:0]       exec_reg_out,
    input  logic             exec_out_valid,
    output logic [2:0]       operand_id_reg,
    output logic [3:0]       instr_ptr_id_reg,
    output logic [1:0]       op1_sel,
    output logic [1:0]       op2_sel,
    output logic [1:0]       operation_sel,
    output logic [4:0]       reg_wr_en
);
    localparam int PTR_W = $clog2(OUT_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START_RST, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {OP_ADV, OP_BXL, OP_BST, OP_JNZ, OP_BXC, OP_OUT, OP_BDV, OP_CDV} opcode_t;

    localparam logic [1:0] SEL_COMBO = 2'd0, SEL_LIT = 2'd1, SEL_REG_B = 2'd2, SEL_REG_C = 2'd3;
    localparam logic [1:0] OPN_SHIFT = 2'd0, OPN_XOR = 2'd1, OPN_MOD = 2'd2, OPN_JUMP = 2'd3;

    state_t           state_q;
    logic [3:0]       wptr_q;
    logic             load_ready_q, prog_loaded_q, busy_q, done_q, exec_rst_n_q, overflow_q;
    logic [CYC_W-1:0] cycle_cnt_q;
    logic [PTR_W:0]   rd_ptr_q, wr_ptr_q;
    logic [2:0]       prog_mem [16];
    logic [2:0]       fifo_mem [OUT_DEPTH];

    logic load_fire, fifo_empty, fifo_full, pop, push_req, push_ok;

    assign load_fire  = bus.load_valid && load_ready_q;
    assign fifo_empty = (rd_ptr_q == wr_ptr_q);
    assign fifo_full  = (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]) && (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]);
    assign pop        = !fifo_empty && bus.out_ready;
    assign push_req   = (state_q == S_RUN) && exec_out_valid;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    // NOTE: storage arrays have no reset; only the pointers that qualify their contents are reset.
    always_ff @(posedge clk) begin
        if (load_fire) prog_mem[wptr_q] <= bus.load_data;
        if (push_ok)   fifo_mem[wr_ptr_q[PTR_W-1:0]] <= exec_reg_out;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            load_ready_q  <= 1'b0;
            prog_loaded_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            exec_rst_n_q  <= 1'b0;
            overflow_q    <= 1'b0;
            cycle_cnt_q   <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            if (pop)                 rd_ptr_q   <= rd_ptr_q + 1'b1;
            if (push_ok)             wr_ptr_q   <= wr_ptr_q + 1'b1;
            if (push_req && !push_ok) overflow_q <= 1'b1;

            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state_q       <= S_LOAD;
                        wptr_q        <= '0;
                        load_ready_q  <= 1'b1;
                        prog_loaded_q <= 1'b0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        exec_rst_n_q  <= 1'b0;
                    end else if (start && prog_loaded_q) begin
                        state_q      <= S_START_RST;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        exec_rst_n_q <= 1'b0;
                        overflow_q   <= 1'b0;
                        cycle_cnt_q  <= '0;
                        rd_ptr_q     <= '0;
                        wr_ptr_q     <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_fire) begin
                        wptr_q <= wptr_q + 4'd1;
                        if (wptr_q == 4'd15) begin
                            state_q       <= S_IDLE;
                            load_ready_q  <= 1'b0;
                            busy_q        <= 1'b0;
                            prog_loaded_q <= 1'b1;
                        end
                    end
                end
                S_START_RST: begin
                    state_q      <= S_RUN;
                    exec_rst_n_q <= 1'b1;
                end
                S_RUN: begin
                    if (!exec_halt && cycle_cnt_q != {CYC_W{1'b1}}) cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    if (exec_halt) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_empty ? 3'd0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign prog_loaded    = prog_loaded_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = overflow_q;
    assign cycle_cnt      = cycle_cnt_q;
    assign exec_rst_n     = exec_rst_n_q;

    logic [3:0] operand_ptr;
    opcode_t    cur_op;

    assign operand_ptr      = exec_instr_ptr + 4'd1;
    assign cur_op           = opcode_t'(prog_mem[exec_instr_ptr]);
    assign operand_id_reg   = prog_mem[operand_ptr];
    assign instr_ptr_id_reg = exec_instr_ptr;

    // NOTE: every decode output gets a default first so no path through the case can infer a latch.
    always_comb begin
        op1_sel       = SEL_COMBO;
        op2_sel       = SEL_COMBO;
        operation_sel = OPN_SHIFT;
        reg_wr_en     = 5'b00000;
        unique case (cur_op)
            OP_ADV: reg_wr_en = 5'b00001;
            OP_BXL: begin
                op1_sel       = SEL_REG_B;
                op2_sel       = SEL_LIT;
                operation_sel = OPN_XOR;
                reg_wr_en     = 5'b00010;
            end
            OP_BST: begin
                operation_sel = OPN_MOD;
                reg_wr_en     = 5'b00010;
            end
            OP_JNZ: operation_sel = OPN_JUMP;
            OP_BXC: begin
                op1_sel       = SEL_REG_B;
                op2_sel       = SEL_REG_C;
                operation_sel = OPN_XOR;
                reg_wr_en     = 5'b00010;
            end
            OP_OUT: begin
                operation_sel = OPN_MOD;
                reg_wr_en     = 5'b01000;
            end
            OP_BDV: reg_wr_en = 5'b00010;
            OP_CDV: reg_wr_en = 5'b00100;
            default: reg_wr_en = 5'b00000;
        endcase
    end
endmodule
